// File: rtl/astar_pkg.sv
// rtl/astar_pkg.sv - shared entry format and key helpers for the A* pipeline
package astar_pkg;
  localparam int CELL_COLUMN_WIDTH = 4;
  localparam int CELL_ROW_WIDTH    = 4;
  localparam int F_SCORE_WIDTH     = 8;
  localparam int H_SCORE_WIDTH     = 7;
  localparam int DATA_WIDTH        = CELL_COLUMN_WIDTH + CELL_ROW_WIDTH +
                                     F_SCORE_WIDTH + H_SCORE_WIDTH + 1;

  typedef struct packed {
    logic [CELL_COLUMN_WIDTH-1:0] col;
    logic [CELL_ROW_WIDTH-1:0]    row;
    logic [F_SCORE_WIDTH-1:0]     f;
    logic [H_SCORE_WIDTH-1:0]     h;
    logic                         empty;
  } entry_t;

  localparam entry_t EMPTY_ENTRY = entry_t'(DATA_WIDTH'(1));

  typedef enum logic [1:0] {
    SEL_HOLD  = 2'd0,
    SEL_LEFT  = 2'd1,
    SEL_RIGHT = 2'd2,
    SEL_NEW   = 2'd3
  } slot_sel_e;

  // Key is {f, h}; smaller key means higher priority.
  function automatic logic key_le(entry_t a, entry_t b);
    return {a.f, a.h} <= {b.f, b.h};
  endfunction

  function automatic logic same_cell(entry_t a, entry_t b);
    return (a.col == b.col) && (a.row == b.row);
  endfunction
endpackage

// File: rtl/open_list_slot.sv
// rtl/open_list_slot.sv - one open-list slot register with its key/cell compare flags
module open_list_slot
  import astar_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic [1:0]            sel_i,
  input  logic [DATA_WIDTH-1:0] new_i,
  input  logic [DATA_WIDTH-1:0] left_i,
  input  logic [DATA_WIDTH-1:0] right_i,
  output logic [DATA_WIDTH-1:0] slot_o,
  output logic                  le_o,
  output logic                  dup_o
);
  entry_t slot_q, slot_d, new_e;

  assign new_e  = entry_t'(new_i);
  assign slot_o = slot_q;
  assign le_o   = ~slot_q.empty & key_le(slot_q, new_e);
  assign dup_o  = ~slot_q.empty & same_cell(slot_q, new_e);

  always_comb begin
    slot_d = slot_q;
    case (slot_sel_e'(sel_i))
      SEL_LEFT:  slot_d = entry_t'(left_i);
      SEL_RIGHT: slot_d = entry_t'(right_i);
      SEL_NEW:   slot_d = new_e;
      default:   slot_d = slot_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= EMPTY_ENTRY;
    end else if (flush_i) begin
      slot_q <= EMPTY_ENTRY;
    end else begin
      slot_q <= slot_d;
    end
  end
endmodule

// File: rtl/open_list_pq.sv
// rtl/open_list_pq.sv - sorted A* open list with pop-min and decrease-key on duplicate cells
module open_list_pq
  import astar_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [DATA_WIDTH-1:0]      push_data,
  output logic                       pop_valid,
  input  logic                       pop_ready,
  output logic [DATA_WIDTH-1:0]      pop_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] slot_q [DEPTH];
  logic [DEPTH-1:0] le, dup, dup_live, rep_vec, thru_d, before_d, le_hi, le_lo;
  slot_sel_e sel [DEPTH];
  logic pop_fire, push_live, drop, rep, ins, new_ins;
  logic [CW-1:0] count_q, count_d;

  assign pop_fire  = pop_valid & pop_ready;
  assign push_live = push_valid & push_ready & ~push_data[0];

  // The head being popped this cycle cannot be the duplicate.
  assign dup_live = dup & ~DEPTH'(pop_fire);
  assign rep_vec  = dup_live & ~le;
  assign drop     = |(dup_live & le);
  assign rep      = |rep_vec;
  assign ins      = push_live & ~drop;
  assign new_ins  = ins & ~rep;

  // rep_vec is one-hot or zero: thru_d marks slots at/after it, before_d strictly after.
  assign thru_d   = ~(rep_vec - DEPTH'(1));
  assign before_d = thru_d & ~rep_vec;
  assign le_hi    = {1'b0, le[DEPTH-1:1]};
  assign le_lo    = {le[DEPTH-2:0], 1'b1};

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = SEL_HOLD;
      if (pop_fire) begin
        if (!ins || le_hi[i])        sel[i] = SEL_RIGHT;
        else if (le[i] || i == 0)    sel[i] = SEL_NEW;
        else if (thru_d[i])          sel[i] = SEL_RIGHT;
      end else if (ins) begin
        if (le[i])                   sel[i] = SEL_HOLD;
        else if (le_lo[i])           sel[i] = SEL_NEW;
        else if (!before_d[i])       sel[i] = SEL_LEFT;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [DATA_WIDTH-1:0] left_w, right_w;
    if (g == 0) begin : g_first
      assign left_w = EMPTY_ENTRY;
    end else begin : g_mid_l
      assign left_w = slot_q[g-1];
    end
    if (g == DEPTH - 1) begin : g_last
      assign right_w = EMPTY_ENTRY;
    end else begin : g_mid_r
      assign right_w = slot_q[g+1];
    end

    open_list_slot u_slot (
      .clk     (clk),
      .rst     (rst),
      .flush_i (flush),
      .sel_i   (sel[g]),
      .new_i   (push_data),
      .left_i  (left_w),
      .right_i (right_w),
      .slot_o  (slot_q[g]),
      .le_o    (le[g]),
      .dup_o   (dup[g])
    );
  end

  always_comb begin
    count_d = count_q;
    if (new_ins && !pop_fire)      count_d = count_q + CW'(1);
    else if (pop_fire && !new_ins) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign push_ready = ~full;
  assign pop_valid  = ~empty;
  assign pop_data   = slot_q[0];
endmodule

// File: tb/tb_open_list_pq.sv
// tb/tb_open_list_pq.sv - self-checking bench for open_list_pq against a queue-based model
module tb_open_list_pq;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push_valid = 1'b0;
  logic        pop_ready = 1'b0;
  logic        flush = 1'b0;
  logic [23:0] push_data = '0;
  logic        push_ready, pop_valid, full, empty;
  logic [23:0] pop_data;
  logic [4:0]  count;

  int n_pass = 0;
  int n_total = 0;
  logic [23:0] mq[$];

  localparam logic [32:0] EMPTY_STATUS = {5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000001};

  open_list_pq #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_data  (push_data),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .pop_data   (pop_data),
    .flush      (flush),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] mk(int c, int r, int f, int h);
    return {4'(c), 4'(r), 8'(f), 7'(h), 1'b0};
  endfunction

  function automatic logic [32:0] act_status();
    return {count, full, empty, push_ready, pop_valid, pop_data};
  endfunction

  function automatic logic [32:0] exp_status();
    int n;
    logic [23:0] head;
    n = mq.size();
    head = 24'h000001;
    if (n > 0) head = mq[0];
    return {5'(n), n == DEPTH, n == 0, n != DEPTH, n != 0, head};
  endfunction

  // Priority-queue semantics straight from the rules: pop first, then push.
  function automatic void model_step(logic pop, logic push, logic [23:0] d);
    logic ready;
    int dup, pos;
    ready = (mq.size() < DEPTH);
    if (pop && mq.size() > 0) void'(mq.pop_front());
    if (!(push && ready) || d[0]) return;
    dup = -1;
    foreach (mq[j]) if (mq[j][23:16] == d[23:16]) dup = j;
    if (dup >= 0) begin
      if (d[15:1] >= mq[dup][15:1]) return;
      mq.delete(dup);
    end
    pos = 0;
    foreach (mq[j]) if (mq[j][15:1] <= d[15:1]) pos++;
    mq.insert(pos, d);
  endfunction

  task automatic step(input logic pv, input logic [23:0] pd, input logic pr, input logic fl = 1'b0);
    push_valid = pv; push_data = pd; pop_ready = pr; flush = fl;
    @(posedge clk);
    if (fl) mq.delete();
    else model_step(pr, pv, pd);
    #1;
    push_valid = 1'b0; pop_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (act_status() !== EMPTY_STATUS) $display("FAIL reset_state: got %h want %h", act_status(), EMPTY_STATUS);
    else n_pass++;
    rst = 1'b0;
    step(1'b0, '0, 1'b1);
    n_total++;
    if (act_status() !== EMPTY_STATUS) $display("FAIL idle_after_reset: got %h want %h", act_status(), EMPTY_STATUS);
    else n_pass++;
  endtask

  task automatic test_basic_order();
    logic [23:0] pushes [3];
    logic [7:0]  f_exp [3];
    pushes = '{mk(3, 4, 10, 5), mk(1, 1, 7, 7), mk(2, 2, 12, 1)};
    f_exp  = '{8'd7, 8'd10, 8'd12};
    for (int i = 0; i < 3; i++) step(1'b1, pushes[i], 1'b0);
    n_total++;
    if (count !== 5'd3) $display("FAIL basic_count3: got %0d want 3", count);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (pop_data[15:8] !== f_exp[k]) $display("FAIL basic_pop%0d_f: got %0d want %0d", k, pop_data[15:8], f_exp[k]);
      else n_pass++;
      step(1'b0, '0, 1'b1);
    end
    n_total++;
    if (act_status() !== EMPTY_STATUS) $display("FAIL basic_drained: got %h want %h", act_status(), EMPTY_STATUS);
    else n_pass++;
  endtask

  task automatic test_equal_keys();
    logic [23:0] a, b, c;
    a = mk(0, 1, 9, 4); b = mk(1, 0, 9, 4); c = mk(2, 2, 9, 3);
    step(1'b1, a, 1'b0);
    step(1'b1, b, 1'b0);
    n_total++;
    if (pop_data !== a) $display("FAIL tie_head_a: got %h want %h", pop_data, a);
    else n_pass++;
    step(1'b1, c, 1'b0);
    n_total++;
    if (pop_data !== c) $display("FAIL tie_lower_h_first: got %h want %h", pop_data, c);
    else n_pass++;
    step(1'b0, '0, 1'b1);
    n_total++;
    if (pop_data !== a) $display("FAIL tie_second_a: got %h want %h", pop_data, a);
    else n_pass++;
    step(1'b0, '0, 1'b1);
    n_total++;
    if (pop_data !== b) $display("FAIL tie_third_b: got %h want %h", pop_data, b);
    else n_pass++;
    step(1'b0, '0, 1'b1);
    n_total++;
    if (empty !== 1'b1) $display("FAIL tie_empty: got %b want 1", empty);
    else n_pass++;
  endtask

  task automatic test_decrease_key();
    step(1'b1, mk(5, 5, 20, 3), 1'b0);
    step(1'b1, mk(6, 6, 16, 0), 1'b0);
    step(1'b1, mk(5, 5, 14, 3), 1'b0);
    n_total++;
    if ({count, pop_data} !== {5'd2, mk(5, 5, 14, 3)})
      $display("FAIL dec_key_replace: got %0d/%h want 2/%h", count, pop_data, mk(5, 5, 14, 3));
    else n_pass++;
    step(1'b1, mk(5, 5, 18, 3), 1'b0);
    n_total++;
    if ({count, pop_data} !== {5'd2, mk(5, 5, 14, 3)})
      $display("FAIL dec_key_drop: got %0d/%h want 2/%h", count, pop_data, mk(5, 5, 14, 3));
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      step(1'b0, '0, 1'b1);
      n_total++;
      if (act_status() !== exp_status()) $display("FAIL dec_key_drain%0d: got %h want %h", k, act_status(), exp_status());
      else n_pass++;
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, mk(i, 0, $urandom_range(0, 40), $urandom_range(0, 127)), 1'b0);
    n_total++;
    if ({count, full, push_ready} !== {5'd16, 1'b1, 1'b0})
      $display("FAIL full_flags: got %0d/%b/%b want 16/1/0", count, full, push_ready);
    else n_pass++;
    step(1'b1, mk(0, 1, 0, 0), 1'b0);
    n_total++;
    if (act_status() !== exp_status()) $display("FAIL full_push_held: got %h want %h", act_status(), exp_status());
    else n_pass++;
    step(1'b0, '0, 1'b1);
    step(1'b1, mk(1, 1, $urandom_range(0, 40), $urandom_range(0, 127)), 1'b1);
    n_total++;
    if (count !== 5'd15) $display("FAIL full_pop_push_count: got %0d want 15", count);
    else n_pass++;
    for (int k = 0; k < 15; k++) begin
      n_total++;
      if (act_status() !== exp_status()) $display("FAIL full_drain%0d: got %h want %h", k, act_status(), exp_status());
      else n_pass++;
      step(1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_pop_push_dup_head();
    logic [23:0] nd;
    step(1'b1, mk(2, 3, $urandom_range(0, 30), $urandom_range(0, 9)), 1'b0);
    step(1'b1, mk(4, 5, $urandom_range(0, 30), $urandom_range(0, 9)), 1'b0);
    step(1'b1, mk(6, 7, $urandom_range(0, 30), $urandom_range(0, 9)), 1'b0);
    nd = {pop_data[23:16], 8'($urandom_range(0, 40)), 7'($urandom_range(0, 9)), 1'b0};
    step(1'b1, nd, 1'b1);
    n_total++;
    if (count !== 5'd3) $display("FAIL dup_head_count: got %0d want 3", count);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (act_status() !== exp_status()) $display("FAIL dup_head_order%0d: got %h want %h", k, act_status(), exp_status());
      else n_pass++;
      step(1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_random();
    logic [23:0] d;
    logic pv, pr, fl;
    for (int i = 0; i < 400; i++) begin
      pv = ($urandom_range(0, 99) < 60);
      pr = ($urandom_range(0, 99) < 45);
      fl = ($urandom_range(0, 99) < 2);
      d  = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3));
      if ($urandom_range(0, 99) < 5) d[0] = 1'b1;
      step(pv, d, pr, fl);
      n_total++;
      if (act_status() !== exp_status()) $display("FAIL random_cycle%0d: got %h want %h", i, act_status(), exp_status());
      else n_pass++;
    end
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) step(1'b1, mk(i, 9, $urandom_range(0, 50), $urandom_range(0, 50)), 1'b0);
    n_total++;
    if (count !== 5'd8) $display("FAIL pre_reset_count: got %0d want 8", count);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    mq.delete();
    n_total++;
    if (act_status() !== EMPTY_STATUS) $display("FAIL async_reset_clear: got %h want %h", act_status(), EMPTY_STATUS);
    else n_pass++;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    step(1'b1, mk(1, 2, 3, 4) | 24'h1, 1'b0);
    n_total++;
    if (act_status() !== EMPTY_STATUS) $display("FAIL empty_bit_push: got %h want %h", act_status(), EMPTY_STATUS);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_order();
    test_equal_keys();
    test_decrease_key();
    test_full();
    test_pop_push_dup_head();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
